// File: rtl/seg7_scan_capture_if.sv
// Display-side bus of the 7-segment capture block: sampled segment/anode lines,
// error clear and the decoded results.
interface seg7_scan_capture_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   an_in;
   logic                    err_clear;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_done;
   logic                    pattern_err;

   modport master (
      output seg_in, an_in, err_clear,
      input  digits_out, digit_valid, frame_done, pattern_err
   );

   modport slave (
      input  seg_in, an_in, err_clear,
      output digits_out, digit_valid, frame_done, pattern_err
   );
endinterface

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed active-low 7-segment display: qualifies each scan slot as
// stable and inverse-decodes its segment pattern back to a hex nibble per digit.

// Per-digit capture register: nibble, legality of last commit, seen-this-frame.
module seg7_scan_capture_lane (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       wr,
   input  logic       legal,
   input  logic [3:0] nib,
   input  logic       frame_clr,
   output logic [3:0] digit,
   output logic       valid,
   output logic       seen
);
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         digit <= 4'h0;
         valid <= 1'b0;
         seen  <= 1'b0;
      end else begin
         if (wr && legal) digit <= nib;
         if (wr) valid <= legal;
         // a commit landing on the frame boundary survives the clear
         if (wr) seen <= 1'b1;
         else if (frame_clr) seen <= 1'b0;
      end
   end
endmodule

module seg7_scan_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input logic                clock,
   input logic                reset_n,
   seg7_scan_capture_if.slave bus
);
   localparam int            CW      = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   typedef struct packed {
      logic [NUM_DIGITS-1:0] sel;
      logic                  legal;
      logic [3:0]            nib;
   } cmt_t;

   logic [6:0]                  seg_m, seg_s;
   logic [NUM_DIGITS-1:0]       an_m, an_s;
   logic [NUM_DIGITS+6:0]       prev;
   logic [CW-1:0]               cnt;
   logic                        committed;
   logic                        changed, slot_ok, commit_now;
   logic [3:0]                  dec_nib;
   logic                        dec_legal;
   cmt_t                        cmt_q;
   logic                        cmt_vld;
   logic [NUM_DIGITS-1:0]       seen;
   logic                        seen_all;
   logic [NUM_DIGITS-1:0][3:0]  digits;
   logic [NUM_DIGITS-1:0]       valid;
   logic                        frame_q, err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         seg_m <= '0;
         seg_s <= '0;
         an_m  <= '0;
         an_s  <= '0;
      end else begin
         seg_m <= bus.seg_in;
         seg_s <= seg_m;
         an_m  <= bus.an_in;
         an_s  <= an_m;
      end
   end

   assign changed  = {an_s, seg_s} != prev;
   assign slot_ok  = $onehot(~an_s);
   // a sample that differs from the stable run never commits, even on the saturating cycle
   assign commit_now = slot_ok && !changed && !committed && (cnt == CNT_MAX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev      <= '0;
         cnt       <= '0;
         committed <= 1'b0;
      end else begin
         prev <= {an_s, seg_s};
         if (changed) begin
            cnt       <= '0;
            committed <= 1'b0;
         end else if (!slot_ok) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
         if (commit_now) committed <= 1'b1;
      end
   end

   always_comb begin
      dec_legal = 1'b1;
      dec_nib   = 4'h0;
      case (seg_s)
         7'b1000000: dec_nib = 4'h0;
         7'b1111001: dec_nib = 4'h1;
         7'b0100100: dec_nib = 4'h2;
         7'b0110000: dec_nib = 4'h3;
         7'b0011001: dec_nib = 4'h4;
         7'b0010010: dec_nib = 4'h5;
         7'b0000010: dec_nib = 4'h6;
         7'b1111000: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0011000: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b0000011: dec_nib = 4'hB;
         7'b1000110: dec_nib = 4'hC;
         7'b0100001: dec_nib = 4'hD;
         7'b0000110: dec_nib = 4'hE;
         7'b0001110: dec_nib = 4'hF;
         default:    dec_legal = 1'b0;
      endcase
   end

   // one register stage between qualification and the digit registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmt_vld <= 1'b0;
         cmt_q   <= '0;
      end else begin
         cmt_vld <= commit_now;
         if (commit_now) cmt_q <= '{sel: ~an_s, legal: dec_legal, nib: dec_nib};
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
      seg7_scan_capture_lane u_lane (
         .clock     (clock),
         .reset_n   (reset_n),
         .wr        (cmt_vld && cmt_q.sel[i]),
         .legal     (cmt_q.legal),
         .nib       (cmt_q.nib),
         .frame_clr (seen_all),
         .digit     (digits[i]),
         .valid     (valid[i]),
         .seen      (seen[i])
      );
   end

   assign seen_all = &seen;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         frame_q <= seen_all;
         if (cmt_vld && !cmt_q.legal) err_q <= 1'b1;
         else if (bus.err_clear)      err_q <= 1'b0;
      end
   end

   assign bus.digits_out  = digits;
   assign bus.digit_valid = valid;
   assign bus.frame_done  = frame_q;
   assign bus.pattern_err = err_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: table of scan slots with a scoreboard of expected
// outputs, plus hand-written latency and mid-scan reset sequences.
module tb_seg7_scan_capture;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   nvec = 0;
   int   nmis = 0;
   int   frame_cnt = 0;

   always #5 clock = ~clock;

   seg7_scan_capture_if #(.NUM_DIGITS(4)) bus ();

   seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always @(negedge clock) if (bus.frame_done) frame_cnt++;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        clr;
      int          hold;
      logic [15:0] dig;
      logic [3:0]  vld;
      logic        err;
      int          frames;
   } vec_t;

   vec_t vecs[22];
   vec_t sb[$];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      // an, seg, clr, hold, digits, valid, err, cumulative frame pulses
      vecs[0]  = '{4'b1110, 7'b1111001, 1'b0, 8,  16'h0001, 4'b0001, 1'b0, 0};
      vecs[1]  = '{4'b1101, 7'b0001000, 1'b0, 8,  16'h00A1, 4'b0011, 1'b0, 0};
      vecs[2]  = '{4'b1011, 7'b1000000, 1'b0, 8,  16'h00A1, 4'b0111, 1'b0, 0};
      vecs[3]  = '{4'b0111, 7'b0001110, 1'b0, 8,  16'hF0A1, 4'b1111, 1'b0, 0};
      vecs[4]  = '{4'b1110, 7'b1111001, 1'b0, 8,  16'hF0A1, 4'b1111, 1'b0, 1};
      vecs[5]  = '{4'b1101, 7'b0001000, 1'b0, 8,  16'hF0A1, 4'b1111, 1'b0, 1};
      vecs[6]  = '{4'b1011, 7'b1000000, 1'b0, 8,  16'hF0A1, 4'b1111, 1'b0, 1};
      vecs[7]  = '{4'b0111, 7'b0001110, 1'b0, 8,  16'hF0A1, 4'b1111, 1'b0, 1};
      vecs[8]  = '{4'b1011, 7'b1111111, 1'b0, 8,  16'hF0A1, 4'b1011, 1'b1, 2};
      vecs[9]  = '{4'b1111, 7'b1111111, 1'b1, 2,  16'hF0A1, 4'b1011, 1'b0, 2};
      vecs[10] = '{4'b1110, 7'b0010010, 1'b0, 8,  16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[11] = '{4'b1110, 7'b1111000, 1'b0, 2,  16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[12] = '{4'b1111, 7'b1111000, 1'b0, 10, 16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[13] = '{4'b1100, 7'b0000000, 1'b0, 20, 16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[14] = '{4'b1111, 7'b0000000, 1'b0, 20, 16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[15] = '{4'b1110, 7'b1111111, 1'b0, 7,  16'hF0A5, 4'b1011, 1'b0, 2};
      vecs[16] = '{4'b1110, 7'b1111111, 1'b1, 1,  16'hF0A5, 4'b1010, 1'b1, 2};
      vecs[17] = '{4'b1111, 7'b1111111, 1'b1, 1,  16'hF0A5, 4'b1010, 1'b0, 2};
      vecs[18] = '{4'b1110, 7'b0011001, 1'b0, 8,  16'hF0A4, 4'b1011, 1'b0, 2};
      vecs[19] = '{4'b1101, 7'b0110000, 1'b0, 8,  16'hF034, 4'b1011, 1'b0, 2};
      vecs[20] = '{4'b1011, 7'b0100100, 1'b0, 8,  16'hF234, 4'b1111, 1'b0, 2};
      vecs[21] = '{4'b0111, 7'b1111001, 1'b0, 8,  16'h1234, 4'b1111, 1'b0, 2};

      bus.an_in = 4'b1111;
      bus.seg_in = 7'b1111111;
      bus.err_clear = 1'b0;

      tick(3);
      chk("reset digits", bus.digits_out, 16'h0);
      chk("reset valid", bus.digit_valid, 4'h0);
      chk("reset frame", bus.frame_done, 1'b0);
      chk("reset err", bus.pattern_err, 1'b0);

      // commit latency: visible on edge 7 counting the first sampling edge as 0
      reset_n = 1'b1;
      bus.an_in = 4'b1110;
      bus.seg_in = 7'b0110000;
      tick(7);
      chk("latency early valid", bus.digit_valid, 4'b0000);
      tick(1);
      chk("latency digit", bus.digits_out[3:0], 4'h3);
      chk("latency valid", bus.digit_valid, 4'b0001);
      tick(10);
      chk("held digit", bus.digits_out, 16'h0003);
      chk("held valid", bus.digit_valid, 4'b0001);
      chk("held frames", frame_cnt, 0);
      chk("held err", bus.pattern_err, 1'b0);

      frame_cnt = 0;
      for (int i = 0; i < 22; i++) begin
         bus.an_in = vecs[i].an;
         bus.seg_in = vecs[i].seg;
         bus.err_clear = vecs[i].clr;
         sb.push_back(vecs[i]);
         tick(vecs[i].hold);
         if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", i), 1, 0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d digits", i), bus.digits_out, e.dig);
            chk($sformatf("v%0d valid", i), bus.digit_valid, e.vld);
            chk($sformatf("v%0d err", i), bus.pattern_err, e.err);
            chk($sformatf("v%0d frames", i), frame_cnt, e.frames);
         end
      end
      bus.err_clear = 1'b0;

      // reset in the middle of a slot: outputs drop without waiting for a clock edge
      bus.an_in = 4'b1110;
      bus.seg_in = 7'b0011000;
      tick(3);
      reset_n = 1'b0;
      #1;
      chk("async rst digits", bus.digits_out, 16'h0);
      chk("async rst valid", bus.digit_valid, 4'h0);
      chk("async rst frame", bus.frame_done, 1'b0);
      chk("async rst err", bus.pattern_err, 1'b0);
      tick(2);
      reset_n = 1'b1;
      frame_cnt = 0;
      tick(8);
      bus.an_in = 4'b1101; bus.seg_in = 7'b0000000; tick(8);
      bus.an_in = 4'b1011; bus.seg_in = 7'b1111000; tick(8);
      bus.an_in = 4'b0111; bus.seg_in = 7'b0000010; tick(8);
      chk("rescan frames before", frame_cnt, 0);
      bus.an_in = 4'b1111; bus.seg_in = 7'b1111111; tick(2);
      chk("rescan digits", bus.digits_out, 16'h6789);
      chk("rescan valid", bus.digit_valid, 4'b1111);
      chk("rescan frames", frame_cnt, 1);
      tick(10);
      chk("rescan frames idle", frame_cnt, 1);
      chk("rescan err", bus.pattern_err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the board's 7-segment display interface.
- Samples a multiplexed, active-low segment bus and an active-low anode-select bus, qualifies each scan slot as stable, and inverse-decodes the segment pattern back to a 4-bit hex nibble per digit.
- Used for on-board loopback checking of the display path and for capturing the display outputs of an external board.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits and anode lines.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (range 2..255).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- seg_in  in  7  segment bus, active-low; bit0=a … bit5=f, bit6=g.
- an_in  in  NUM_DIGITS  anode select, active-low; bit i low selects digit i.
- err_clear  in  1  synchronous clear of pattern_err.
- digits_out  out  4*NUM_DIGITS  captured nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i set when digit i's last commit decoded legally.
- frame_done  out  1  one-cycle pulse when all digits have been committed since the previous pulse.
- pattern_err  out  1  sticky flag for an illegal segment pattern.

Behaviour:
- Reset (async assert, sync-safe deassert): digits_out=0, digit_valid=0, frame_done=0, pattern_err=0; synchronizers, stability counter, committed flag and seen-mask all cleared.
- Input stage: seg_in and an_in each pass through a 2-flop synchronizer to give seg_s and an_s.
- Change detection:
  - Register prev = {an_s, seg_s} every cycle.
  - If {an_s, seg_s} != prev: cnt <= 0 and committed <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- Slot qualification:
  - an_s must have exactly one bit low.
  - All-high (blanking) or more than one bit low: cnt held at 0, no commit, no error.
- Commit: fires for one cycle when cnt==STABLE_CYCLES-1, committed==0 and an_s is one-hot. It sets committed<=1, so there is exactly one commit per stable run.
- Decode table (seg_s, bits 6..0, to nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=B
  - 1000110=C, 0100001=D, 0000110=E, 0001110=F
- Legal commit on digit i: nibble i is written, digit_valid[i]<=1, seen[i]<=1.
- Illegal pattern (any other of the 112 codes) on digit i:
  - digits_out nibble i is unchanged.
  - digit_valid[i]<=0, seen[i]<=1, pattern_err<=1.
- Latency: with inputs held constant from clock edge 0, the commit result is visible on the outputs after edge STABLE_CYCLES+3. For the default this is edge 7.
- frame_done:
  - Asserted for exactly one cycle on the edge after seen becomes all ones.
  - seen is cleared on that same edge.
  - A commit in that cycle sets its seen bit after the clear.
- err_clear: clears pattern_err on the next edge. If an illegal commit occurs in the same cycle, set wins and pattern_err stays 1.
- A glitch shorter than STABLE_CYCLES restarts the count; the previously committed value is retained.
- Reset mid-scan: all state returns to reset values immediately; capture restarts from scratch after release.

Test Plan:
- Hold an_in=1110, seg_in=0110000 for 10 cycles -> digits_out[3:0]=3 and digit_valid=0001 exactly 7 edges after the first sampling edge; no second commit while the input is held.
- Scan 4 digits with seg patterns for 1,A,0,F, 8 cycles per slot -> digits_out=16'hF0A1, digit_valid=1111, and frame_done pulses exactly once per full scan.
- On digit 2, drive seg_in=1111111 (blank, illegal) -> pattern_err=1, digit_valid[2]=0, nibble 2 keeps its old value; err_clear pulse with no new error -> pattern_err=0.
- On digit 0 holding 5, inject a 2-cycle glitch to 7 -> digits_out[3:0] stays 5; an_in=1100 or 1111 held 20 cycles -> no commit, no error.
- Assert err_clear in the same cycle as an illegal commit -> pattern_err remains 1.
- Pull reset_n low mid-scan after capturing 16'h1234 -> all outputs 0 asynchronously; after release, a fresh scan of 9,8,7,6 gives 16'h6789 and one frame_done.
